// File: rtl/gen_selec_mux_dd.sv
// Data-block select sequencer: steps Selec_Mux_DDw through the INIT, MS or read code sequence,
// one code per trans_done, with a per-step abort timer. Optional macro CRONO_READ_EN adds the CRONO codes to the read sequence.
module gen_selec_mux_dd #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_init,
  input  logic       req_ms,
  input  logic       req_leer,
  input  logic       trans_done,
  output logic [3:0] Selec_Mux_DDw,
  output logic       busy,
  output logic       seq_done,
  output logic       seq_error,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_MS    = 3'd2,
    S_FECHA = 3'd3,
    S_HORA  = 3'd4,
    S_CRONO = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [7:0] timer_q, timer_d;
  logic       pend_q;
  logic       active;
  logic       err_d;
  logic [3:0] code_d;

  assign dbg_state = state_q;
  assign active = (state_q == S_INIT) || (state_q == S_MS) || (state_q == S_FECHA) ||
                  (state_q == S_HORA) || (state_q == S_CRONO);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        step_d = 2'd0;
        // pend_q forces the power-on INIT on the first edge out of reset
        if (pend_q || req_init) state_d = S_INIT;
        else if (req_ms)        state_d = S_MS;
        else if (req_leer)      state_d = S_FECHA;
      end
      S_INIT, S_MS: begin
        if (trans_done) state_d = S_DONE;
      end
      S_FECHA: begin
        if (trans_done) begin
          if (step_q == 2'd2) begin
            state_d = S_HORA;
            step_d  = 2'd0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      S_HORA: begin
        if (trans_done) begin
          if (step_q == 2'd2) begin
`ifdef CRONO_READ_EN
            state_d = S_CRONO;
`else
            state_d = S_DONE;
`endif
            step_d  = 2'd0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      S_CRONO: begin
        if (trans_done) begin
          if (step_q == 2'd2) begin
            state_d = S_DONE;
            step_d  = 2'd0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A step that is still waiting when the timer hits its limit is abandoned
    if (active && !trans_done && (timer_q == TMAX)) begin
      state_d = S_IDLE;
      step_d  = 2'd0;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    code_d = 4'b0010;
    case (state_d)
      S_INIT:  code_d = 4'b0000;
      S_MS:    code_d = 4'b0001;
      S_FECHA: code_d = 4'd3 + {2'b00, step_d};
      S_HORA:  code_d = 4'd6 + {2'b00, step_d};
      S_CRONO: code_d = 4'd9 + {2'b00, step_d};
      default: code_d = 4'b0010;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || (step_d != step_q)) timer_d = 8'd0;
    else if (active && !trans_done)                 timer_d = timer_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      step_q        <= 2'd0;
      timer_q       <= 8'd0;
      pend_q        <= 1'b1;
      Selec_Mux_DDw <= 4'b0010;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
      seq_error     <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      timer_q       <= timer_d;
      pend_q        <= 1'b0;
      Selec_Mux_DDw <= code_d;
      busy          <= (state_d != S_IDLE);
      seq_done      <= (state_d == S_DONE);
      seq_error     <= err_d;
    end
  end

endmodule
